// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive path: bit-timer FSM encoding and
// full-speed timing constants.
package usb_rx_pkg;

  typedef enum logic {IDLE, RUN} bit_timer_state_t;

  // 96 MHz system clock / 12 Mbps full-speed bit rate
  localparam int USB_CLKS_PER_BIT = 8;

  // After this many consecutive 1s the transmitter inserts a 0
  localparam int USB_MAX_ONES = 6;

endpackage

// File: rtl/flex_counter.sv
// Rollover counter: counts 0..rollover_val and wraps to 0.
// Priority: clear (to 0) > load (to load_val) > count_enable.
module flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count_out
);

  // Counter register with synchronous clear/load and wrap at rollover_val
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (load) begin
      count_out <= load_val;
    end else if (count_enable) begin
      if (count_out == rollover_val) begin
        count_out <= '0;
      end else begin
        count_out <= count_out + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/rx_bit_timer.sv
// USB RX bit timer and bit unstuffer. Recovers bit timing from data edges,
// samples once per bit, drops stuffed zeros, flags stuffing violations and
// marks every eighth accepted bit.
//
// Output handshake: shift_enable, byte_received and stuff_err are single-cycle
// registered pulses with no back-pressure; the consumer must act on them in
// the cycle they are high.
module rx_bit_timer
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = USB_CLKS_PER_BIT,
  parameter int SAMPLE_PHASE = 3,
  parameter int MAX_ONES     = USB_MAX_ONES
) (
  input  logic clk,
  input  logic n_rst,
  input  logic rcving,
  input  logic d_edge,
  input  logic d_orig,
  output logic shift_enable,
  output logic byte_received,
  output logic stuff_err
);

  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int OW = $clog2(MAX_ONES + 1);

  localparam logic [PW-1:0] PHASE_LAST = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PHASE_SAMP = PW'(SAMPLE_PHASE);
  localparam logic [PW-1:0] PHASE_SYNC = PW'(1);
  localparam logic [OW-1:0] ONES_MAX   = OW'(MAX_ONES);

  bit_timer_state_t state;
  logic [PW-1:0]    phase_cnt;
  logic [2:0]       bit_cnt;
  logic [OW-1:0]    ones_cnt;
  logic             last_bit_q;   // the shift_enable now in flight completes a byte

  logic running;
  logic sample;

  // A packet is active only while in RUN with rcving still asserted
  assign running = (state == RUN) && rcving;
  assign sample  = running && (phase_cnt == PHASE_SAMP);

  // Phase counter: held at 0 when idle; an edge makes the edge cycle phase 0,
  // so the following cycle reads 1
  flex_counter #(
    .WIDTH (PW)
  ) u_phase (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (!running),
    .load         (running && d_edge),
    .load_val     (PHASE_SYNC),
    .count_enable (running),
    .rollover_val (PHASE_LAST),
    .count_out    (phase_cnt)
  );

  // FSM, bit/ones counters and registered output pulses
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      ones_cnt      <= '0;
      last_bit_q    <= 1'b0;
      shift_enable  <= 1'b0;
      byte_received <= 1'b0;
      stuff_err     <= 1'b0;
    end else begin
      shift_enable  <= 1'b0;
      stuff_err     <= 1'b0;
      last_bit_q    <= 1'b0;
      // byte_received trails the eighth shift_enable even if the packet ends
      byte_received <= shift_enable && last_bit_q;
      case (state)
        IDLE: begin
          if (rcving) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!rcving) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            ones_cnt <= '0;
          end else if (sample) begin
            if (ones_cnt < ONES_MAX) begin
              shift_enable <= 1'b1;
              bit_cnt      <= bit_cnt + 3'd1;
              last_bit_q   <= (bit_cnt == 3'd7);
              ones_cnt     <= d_orig ? (ones_cnt + OW'(1)) : '0;
            end else begin
              // Slot after MAX_ONES ones: a 0 is the stuffed bit, a 1 is illegal
              ones_cnt  <= '0;
              stuff_err <= d_orig;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_bit_timer.sv
// Bench for rx_bit_timer: directed scenarios plus random packets. A
// cycle-stamped reference model schedules expected pulses; a negedge monitor
// matches DUT pulses against them.
module tb_rx_bit_timer;
  import usb_rx_pkg::*;

  localparam int CPB    = USB_CLKS_PER_BIT;
  localparam int SAMP   = 3;
  localparam int MAXONE = USB_MAX_ONES;

  localparam logic [1:0] K_SHIFT = 2'd0;
  localparam logic [1:0] K_STUFF = 2'd1;
  localparam logic [1:0] K_BYTE  = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b1;
  logic rcving = 1'b0;
  logic d_edge = 1'b0;
  logic d_orig = 1'b0;
  logic shift_enable;
  logic byte_received;
  logic stuff_err;

  always #5 clk = ~clk;

  rx_bit_timer dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .rcving        (rcving),
    .d_edge        (d_edge),
    .d_orig        (d_orig),
    .shift_enable  (shift_enable),
    .byte_received (byte_received),
    .stuff_err     (stuff_err)
  );

  // ---------------- scoreboard state ----------------
  logic [33:0] exp_q[$];   // {kind, cycle}
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  // reference model: phase = (cycle - anchor) mod CPB while a packet runs
  bit m_run = 1'b0;
  int m_anchor = 0;
  int m_ones = 0;
  int m_bits = 0;

  function automatic void push_exp(input logic [1:0] k, input int c);
    exp_q.push_back({k, c[31:0]});
  endfunction

  function automatic void model_reset();
    m_run = 1'b0;
    m_anchor = 0;
    m_ones = 0;
    m_bits = 0;
  endfunction

  function automatic void model_step(input logic rc, input logic de, input logic dd);
    if (!m_run) begin
      if (rc) begin
        m_run = 1'b1;
        m_anchor = cyc + 1;
      end
    end else if (!rc) begin
      m_run = 1'b0;
      m_ones = 0;
      m_bits = 0;
    end else begin
      if (((cyc - m_anchor) % CPB) == SAMP) begin
        if (m_ones < MAXONE) begin
          push_exp(K_SHIFT, cyc + 1);
          m_ones = dd ? m_ones + 1 : 0;
          m_bits = m_bits + 1;
          if (m_bits == 8) begin
            m_bits = 0;
            push_exp(K_BYTE, cyc + 2);
          end
        end else begin
          m_ones = 0;
          if (dd) push_exp(K_STUFF, cyc + 1);
        end
      end
      if (de) m_anchor = cyc;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input logic rc, input logic de, input logic dd);
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    rcving = rc;
    d_edge = de;
    d_orig = dd;
    if (n_rst) model_step(rc, de, dd);
  endtask

  // One bit slot; an edge at the slot start models an NRZI transition
  task automatic send_bit(input logic b, input int len, input logic with_edge);
    for (int i = 0; i < len; i++) tick(1'b1, with_edge && (i == 0), b);
  endtask

  task automatic start_packet();
    tick(1'b1, 1'b0, 1'b1);
  endtask

  task automatic end_packet(input int idle);
    for (int i = 0; i < idle; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i], CPB, !v[i]);
  endtask

  task automatic do_reset_mid();
    @(negedge clk);
    #1;
    n_rst = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    checks = checks + 1;
    if ({shift_enable, byte_received, stuff_err} !== 3'b000) begin
      errors = errors + 1;
      $display("FAIL reset_outputs: got %b, expected 000", {shift_enable, byte_received, stuff_err});
    end
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    checks = checks + 1;
    if (dut.bit_cnt !== 3'd0) begin
      errors = errors + 1;
      $display("FAIL reset_bit_cnt: got %0d, expected 0", dut.bit_cnt);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic check_kind(input logic v, input logic [1:0] k, input string nm);
    if (v) begin
      checks = checks + 1;
      if (exp_q.size() > 0 && exp_q[0] == {k, cyc[31:0]}) begin
        void'(exp_q.pop_front());
      end else begin
        errors = errors + 1;
        $display("FAIL %s: got pulse at cycle %0d, expected none (next expected %0d)",
                 nm, cyc, (exp_q.size() > 0) ? int'(exp_q[0][31:0]) : -1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (n_rst) begin
      while (exp_q.size() > 0 && int'(exp_q[0][31:0]) < cyc) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL missing_pulse: got nothing, expected kind %0d at cycle %0d",
                 exp_q[0][33:32], exp_q[0][31:0]);
        void'(exp_q.pop_front());
      end
      check_kind(shift_enable, K_SHIFT, "shift_enable");
      check_kind(stuff_err, K_STUFF, "stuff_err");
      check_kind(byte_received, K_BYTE, "byte_received");
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    #2 n_rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks = checks + 1;
    if ({shift_enable, byte_received, stuff_err} !== 3'b000) begin
      errors = errors + 1;
      $display("FAIL reset_state: got %b, expected 000", {shift_enable, byte_received, stuff_err});
    end
    n_rst = 1'b1;

    // byte 0x80, LSB first, edges on bit boundaries
    start_packet();
    send_byte(8'h80);
    end_packet(4);

    // six 1s, stuffed 0, then 1
    start_packet();
    for (int i = 0; i < 6; i++) send_bit(1'b1, CPB, 1'b0);
    send_bit(1'b0, CPB, 1'b1);
    send_bit(1'b1, CPB, 1'b0);
    end_packet(4);

    // seven consecutive 1s: stuffing violation on the seventh
    start_packet();
    send_bit(1'b0, CPB, 1'b1);
    for (int i = 0; i < 7; i++) send_bit(1'b1, CPB, 1'b0);
    send_bit(1'b0, CPB, 1'b1);
    end_packet(4);

    // resync: edge arriving at phase 5 inside a bit
    start_packet();
    send_bit(1'b0, CPB, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2 * CPB; i++) tick(1'b1, (i == 0), 1'b1);
    send_bit(1'b0, CPB, 1'b1);
    end_packet(4);

    // abort after 5 bits, then a full byte from scratch
    start_packet();
    for (int i = 0; i < 5; i++) send_bit(1'b0, CPB, 1'b1);
    end_packet(3);
    start_packet();
    send_byte(8'h3C);
    send_byte(8'hA5);
    end_packet(4);

    // reset in the middle of a packet, then a clean byte
    start_packet();
    for (int i = 0; i < 4; i++) send_bit(1'b0, CPB, 1'b1);
    for (int i = 0; i < SAMP + 1; i++) tick(1'b1, 1'b0, 1'b1);
    do_reset_mid();
    start_packet();
    send_byte(8'hFF);
    send_byte(8'h01);
    end_packet(4);

    // random packets: biased toward 1s, jittered slots, spurious edges, aborts
    for (int p = 0; p < 25; p++) begin
      int nbits;
      nbits = $urandom_range(1, 40);
      start_packet();
      for (int b = 0; b < nbits; b++) begin
        logic bv;
        int len;
        int extra;
        bv = ($urandom_range(0, 3) != 0);
        len = $urandom_range(CPB - 1, CPB + 1);
        extra = ($urandom_range(0, 9) == 0) ? $urandom_range(1, len - 1) : -1;
        for (int i = 0; i < len; i++) tick(1'b1, ((i == 0) && !bv) || (i == extra), bv);
        if ($urandom_range(0, 59) == 0) begin
          tick(1'b0, 1'b0, 1'b0);
          tick(1'b1, 1'b0, 1'b1);
        end
      end
      end_packet($urandom_range(1, 5));
    end

    end_packet(20);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: got %0d pulses still expected, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
